// File: rtl/sram_port_arbiter_if.sv
// Requester-side bundle for sram_port_arbiter.
// master = compute requesters, slave = arbiter.
interface sram_port_arbiter_if #(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [N_REQ-1:0]            wr_valid;
    logic [N_REQ-1:0]            wr_ready;
    logic [N_REQ*ADDR_WIDTH-1:0] wr_addr;
    logic [N_REQ*DATA_WIDTH-1:0] wr_data;
    logic [N_REQ-1:0]            rd_valid;
    logic [N_REQ-1:0]            rd_ready;
    logic [N_REQ*ADDR_WIDTH-1:0] rd_addr;
    logic [N_REQ-1:0]            rd_rvalid;
    logic [DATA_WIDTH-1:0]       rd_rdata;

    modport master (
        output wr_valid, wr_addr, wr_data,
        output rd_valid, rd_addr,
        input  wr_ready, rd_ready, rd_rvalid, rd_rdata
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        input  rd_valid, rd_addr,
        output wr_ready, rd_ready, rd_rvalid, rd_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// 1W1R SRAM sharer: zero-fill after reset, then per-port round-robin.
// Optional SRAM_ARB_FWD_EN: same-cycle write->read forwarding on collision.
module sram_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int N_REQ      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_port_arbiter_if.slave    bus,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);
    localparam int IW = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE = 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  run;
    logic [IW-1:0]         wr_ptr, rd_ptr;
    logic [IW:0]           wr_pick, rd_pick;
    logic                  wr_go, rd_go;
    logic [IW-1:0]         wr_gi, rd_gi;
    logic                  s1_v, s2_v;
    logic [IW-1:0]         s1_i, s2_i;
    logic [DATA_WIDTH-1:0] rd_src;

    // First valid index scanning upward from p with wrap; MSB = found.
    function automatic logic [IW:0] rr_pick(
        input logic [N_REQ-1:0] v,
        input logic [IW-1:0]    p
    );
        logic [IW:0] r;
        int          j;
        r = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(p) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (v[j[IW-1:0]]) r = {1'b1, j[IW-1:0]};
        end
        return r;
    endfunction

    function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] g);
        return (int'(g) == N_REQ - 1) ? '0 : g + 1'b1;
    endfunction

    // FSM state and init address counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Walk every address once, then stay in RUN until reset
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == INIT) begin
            cnt_nxt = cnt + 1'b1;
            if (&cnt) state_nxt = RUN;
        end
    end

    assign run     = (state == RUN);
    assign wr_pick = rr_pick(bus.wr_valid, wr_ptr);
    assign rd_pick = rr_pick(bus.rd_valid, rd_ptr);
    assign wr_go   = run & wr_pick[IW];
    assign rd_go   = run & rd_pick[IW];
    assign wr_gi   = wr_pick[IW-1:0];
    assign rd_gi   = rd_pick[IW-1:0];

    assign bus.wr_ready = wr_go ? (ONE << wr_gi) : '0;
    assign bus.rd_ready = rd_go ? (ONE << rd_gi) : '0;

    // Round-robin pointers advance past the winner only on a transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_go) wr_ptr <= rr_next(wr_gi);
            if (rd_go) rd_ptr <= rr_next(rd_gi);
        end
    end

    // Write pin register: zero-fill during INIT, granted request in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_csb0  <= 1'b1;
            sram_addr0 <= '0;
            sram_din0  <= '0;
        end else if (!run) begin
            sram_csb0  <= 1'b0;
            sram_addr0 <= cnt;
            sram_din0  <= '0;
        end else if (wr_go) begin
            sram_csb0  <= 1'b0;
            sram_addr0 <= bus.wr_addr[int'(wr_gi)*ADDR_WIDTH +: ADDR_WIDTH];
            sram_din0  <= bus.wr_data[int'(wr_gi)*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            sram_csb0  <= 1'b1;
        end
    end

    // Read pin register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_csb1  <= 1'b1;
            sram_addr1 <= '0;
        end else if (rd_go) begin
            sram_csb1  <= 1'b0;
            sram_addr1 <= bus.rd_addr[int'(rd_gi)*ADDR_WIDTH +: ADDR_WIDTH];
        end else begin
            sram_csb1  <= 1'b1;
        end
    end

`ifdef SRAM_ARB_FWD_EN
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;

    // Note a write/read collision on the pins; it resolves one edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else begin
            fwd_hit  <= !sram_csb0 && !sram_csb1 &&
                        (sram_addr0 == sram_addr1);
            fwd_data <= sram_din0;
        end
    end

    assign rd_src = fwd_hit ? fwd_data : sram_dout1;
`else
    assign rd_src = sram_dout1;
`endif

    // Two-deep tag pipeline and registered read response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v          <= 1'b0;
            s1_i          <= '0;
            s2_v          <= 1'b0;
            s2_i          <= '0;
            bus.rd_rvalid <= '0;
            bus.rd_rdata  <= '0;
        end else begin
            s1_v          <= rd_go;
            s1_i          <= rd_gi;
            s2_v          <= s1_v;
            s2_i          <= s1_i;
            bus.rd_rvalid <= s2_v ? (ONE << s2_i) : '0;
            if (s2_v) bus.rd_rdata <= rd_src;
        end
    end

    // init_done follows RUN by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) init_done <= 1'b0;
        else        init_done <= run;
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 1W1R macro.
// Define SRAM_ARB_FWD_EN to also exercise write->read forwarding.
module tb_sram_port_arbiter;
    logic        clk;
    logic        rst_n;
    logic        init_done;
    logic        sram_csb0, sram_csb1;
    logic [7:0]  sram_addr0, sram_addr1;
    logic [31:0] sram_din0, sram_dout1;

    int nvec = 0;
    int nerr = 0;
    int head = 0;
    int n;
    int nz;
    int qs;

    sram_port_arbiter_if #(.N_REQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    sram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .N_REQ(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .init_done  (init_done),
        .sram_csb0  (sram_csb0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_csb1  (sram_csb1),
        .sram_addr1 (sram_addr1),
        .sram_dout1 (sram_dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: pins registered on posedge, array access on negedge
    logic [31:0] mem [256] = '{default: 32'hA5A5_A5A5};
    logic        m_csb0 = 1'b1;
    logic        m_csb1 = 1'b1;
    logic [7:0]  m_a0, m_a1;
    logic [31:0] m_d0;

    always @(posedge clk) begin
        m_csb0 <= sram_csb0;
        m_csb1 <= sram_csb1;
        m_a0   <= sram_addr0;
        m_a1   <= sram_addr1;
        m_d0   <= sram_din0;
    end

    always @(negedge clk) begin
        if (!m_csb0) mem[m_a0] <= m_d0;
        if (!m_csb1) sram_dout1 <= mem[m_a1];
    end

    // Response log
    logic [1:0]  rq_v [$];
    logic [31:0] rq_d [$];

    always @(negedge clk) begin
        if (bus.rd_rvalid != 2'b00) begin
            rq_v.push_back(bus.rd_rvalid);
            rq_d.push_back(bus.rd_rdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_resp(input string tag, input logic [1:0] ev,
                            input logic [31:0] ed);
        logic [1:0]  v;
        logic [31:0] d;
        v = 2'b00;
        d = 32'h0;
        if (head < rq_v.size()) begin
            v = rq_v[head];
            d = rq_d[head];
            head++;
        end
        chk({tag, "_v"}, 32'(v), 32'(ev));
        chk({tag, "_d"}, d, ed);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.wr_valid = 2'b11;
        bus.rd_valid = 2'b11;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_addr  = '0;
        repeat (3) tick();

        // reset state, requests pending
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'h0);
        chk("rst_rd_ready", 32'(bus.rd_ready), 32'h0);
        chk("rst_rvalid", 32'(bus.rd_rvalid), 32'h0);
        chk("rst_rdata", bus.rd_rdata, 32'h0);
        chk("rst_init_done", 32'(init_done), 32'h0);
        chk("rst_csb0", 32'(sram_csb0), 32'h1);
        chk("rst_csb1", 32'(sram_csb1), 32'h1);
        chk("rst_addr0", 32'(sram_addr0), 32'h0);
        chk("rst_addr1", 32'(sram_addr1), 32'h0);
        chk("rst_din0", sram_din0, 32'h0);

        // zero-fill sequence and init_done latency
        rst_n = 1'b1;
        n = 0;
        while (n < 400) begin
            tick();
            n++;
            if (n == 1) begin
                chk("init_csb0", 32'(sram_csb0), 32'h0);
                chk("init_addr0_first", 32'(sram_addr0), 32'h0);
            end
            if (n == 50) begin
                chk("init_wr_ready", 32'(bus.wr_ready), 32'h0);
                chk("init_rd_ready", 32'(bus.rd_ready), 32'h0);
            end
            if (n == 60) begin
                bus.wr_valid = 2'b00;
                bus.rd_valid = 2'b00;
            end
            if (n == 256) chk("init_addr0_last", 32'(sram_addr0), 32'hFF);
            if (init_done) break;
        end
        chk("init_latency", 32'(n), 32'd257);
        chk("run_csb0_idle", 32'(sram_csb0), 32'h1);

        // every address reads back zero
        nz = 0;
        for (int a = 0; a < 256; a++) begin
            bus.rd_valid = 2'b01;
            bus.rd_addr  = {8'h00, 8'(a)};
            #1;
            if (bus.rd_ready != 2'b01) nz++;
            tick();
        end
        bus.rd_valid = 2'b00;
        repeat (3) tick();
        chk("fill_count", 32'(rq_v.size() - head), 32'd256);
        for (int i = 0; i < 256; i++) begin
            if (head < rq_v.size()) begin
                if (rq_v[head] != 2'b01 || rq_d[head] != 32'h0) nz++;
                head++;
            end
        end
        chk("fill_zero", 32'(nz), 32'h0);

        // req0 writes 0x10, req1 reads it back
        bus.wr_valid = 2'b01;
        bus.wr_addr  = {8'h00, 8'h10};
        bus.wr_data  = {32'h0, 32'h1234_5678};
        #1;
        chk("wr0_ready", 32'(bus.wr_ready), 32'h1);
        tick();
        bus.wr_valid = 2'b00;
        chk("wr0_csb0", 32'(sram_csb0), 32'h0);
        chk("wr0_addr0", 32'(sram_addr0), 32'h10);
        chk("wr0_din0", sram_din0, 32'h1234_5678);
        tick();
        bus.rd_valid = 2'b10;
        bus.rd_addr  = {8'h10, 8'h00};
        #1;
        chk("rd1_ready", 32'(bus.rd_ready), 32'h2);
        tick();
        bus.rd_valid = 2'b00;
        chk("rd1_addr1", 32'(sram_addr1), 32'h10);
        chk("rd1_lat0", 32'(bus.rd_rvalid), 32'h0);
        tick();
        chk("rd1_lat1", 32'(bus.rd_rvalid), 32'h0);
        tick();
        chk("rd1_rvalid", 32'(bus.rd_rvalid), 32'h2);
        chk("rd1_rdata", bus.rd_rdata, 32'h1234_5678);
        tick();
        chk("rd1_pulse", 32'(bus.rd_rvalid), 32'h0);
        head = rq_v.size();

        // both writers at once: pointer sits at 1, so req1 first
        bus.wr_valid = 2'b11;
        bus.wr_addr  = {8'h02, 8'h01};
        bus.wr_data  = {32'h2222_2222, 32'h1111_1111};
        #1;
        chk("wrrr_first", 32'(bus.wr_ready), 32'h2);
        tick();
        bus.wr_valid = 2'b01;
        #1;
        chk("wrrr_second", 32'(bus.wr_ready), 32'h1);
        tick();
        bus.wr_valid = 2'b00;
        tick();

        // both readers held: grants alternate 0,1,0,1,0,1
        bus.rd_valid = 2'b11;
        bus.rd_addr  = {8'h02, 8'h01};
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("rdrr_grant%0d", i), 32'(bus.rd_ready),
                (i % 2 == 0) ? 32'h1 : 32'h2);
            tick();
        end
        bus.rd_valid = 2'b00;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            pop_resp($sformatf("rdrr_a%0d", i), 2'b01, 32'h1111_1111);
            pop_resp($sformatf("rdrr_b%0d", i), 2'b10, 32'h2222_2222);
        end

`ifdef SRAM_ARB_FWD_EN
        // same-edge write and read at 0x20 returns the new value
        bus.wr_valid = 2'b01;
        bus.wr_addr  = {8'h00, 8'h20};
        bus.wr_data  = {32'h0, 32'hDEAD_BEEF};
        bus.rd_valid = 2'b01;
        bus.rd_addr  = {8'h00, 8'h20};
        #1;
        tick();
        bus.wr_valid = 2'b00;
        bus.rd_valid = 2'b00;
        repeat (3) tick();
        pop_resp("fwd", 2'b01, 32'hDEAD_BEEF);
`endif

        // reset one cycle after a read accept
        head = rq_v.size();
        bus.rd_valid = 2'b01;
        bus.rd_addr  = {8'h00, 8'h10};
        #1;
        tick();
        bus.rd_valid = 2'b00;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_csb0", 32'(sram_csb0), 32'h1);
        chk("mid_csb1", 32'(sram_csb1), 32'h1);
        chk("mid_init_done", 32'(init_done), 32'h0);
        qs = rq_v.size();
        repeat (3) tick();
        chk("mid_no_resp", 32'(rq_v.size()), 32'(qs));
        rst_n = 1'b1;
        tick();
        chk("mid_init_csb0", 32'(sram_csb0), 32'h0);
        chk("mid_init_addr0", 32'(sram_addr0), 32'h0);
        n = 1;
        while (n < 400 && !init_done) begin
            tick();
            n++;
        end
        chk("mid_init_latency", 32'(n), 32'd257);
        head = rq_v.size();

        // writes to 0xFF from both; pointer reset to 0, so req1 wins last
        bus.wr_valid = 2'b11;
        bus.wr_addr  = {8'hFF, 8'hFF};
        bus.wr_data  = {32'hBBBB_1111, 32'hAAAA_0000};
        #1;
        chk("wrap_first", 32'(bus.wr_ready), 32'h1);
        tick();
        bus.wr_valid = 2'b10;
        #1;
        chk("wrap_second", 32'(bus.wr_ready), 32'h2);
        tick();
        bus.wr_valid = 2'b00;
        chk("wrap_addr0", 32'(sram_addr0), 32'hFF);
        tick();
        bus.rd_valid = 2'b01;
        bus.rd_addr  = {8'h00, 8'hFF};
        tick();
        bus.rd_addr  = {8'h00, 8'h00};
        tick();
        bus.rd_addr  = {8'h00, 8'h10};
        tick();
        bus.rd_valid = 2'b00;
        repeat (3) tick();
        pop_resp("wrap_ff", 2'b01, 32'hBBBB_1111);
        pop_resp("wrap_00", 2'b01, 32'h0);
        pop_resp("rezero_10", 2'b01, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
